// File: rtl/dmem_responder.sv
// Memory-side responder for data loads/stores: word-organised SRAM with
// byte/halfword lanes, programmable wait states, busy stall and one-cycle ack.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [3:0]  cnt;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  // Decode acts on the live inputs while idle and on the latched copy after
  // acceptance, so the zero-wait path and the waited path share one datapath.
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_f3;

  assign cur_we    = (state == S_IDLE) ? we_i     : we_q;
  assign cur_addr  = (state == S_IDLE) ? addr_i   : addr_q;
  assign cur_wdata = (state == S_IDLE) ? wdata_i  : wdata_q;
  assign cur_f3    = (state == S_IDLE) ? funct3_i : f3_q;

  logic [IDX_W-1:0] idx;
  logic             illegal;
  logic             misaligned;
  logic             out_of_range;
  logic             acc_err;

  assign idx          = cur_addr[IDX_W+1:2];
  assign illegal      = (cur_f3 == 3'b011) || (cur_f3[2:1] == 2'b11) ||
                        (cur_we && cur_f3[2]);
  assign misaligned   = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                        ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
  assign out_of_range = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign acc_err      = illegal || misaligned || out_of_range;

  logic [31:0] rd_word;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] resp_data;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] merged;

  assign rd_word = mem[idx];
  assign shifted = rd_word >> {cur_addr[1:0], 3'b000};

  always_comb begin
    load_data = rd_word;
    case (cur_f3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'b0, shifted[7:0]};
      3'b101:  load_data = {16'b0, shifted[15:0]};
      default: load_data = rd_word;
    endcase
  end

  assign resp_data = (!cur_we && !acc_err) ? load_data : 32'b0;

  // Stores replicate the right-aligned data across lanes and merge under a
  // byte enable so unwritten lanes keep their old contents.
  always_comb begin
    be   = 4'b1111;
    wrep = cur_wdata;
    case (cur_f3[1:0])
      2'b00: begin
        be   = 4'b0001 << cur_addr[1:0];
        wrep = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{cur_wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = cur_wdata;
      end
    endcase
    merged = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = wrep[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RESP && we_q && !err_o) mem[idx] <= merged;
  end

  assign busy_o = ((state == S_IDLE) && req_i) || (state == S_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      f3_q    <= 3'b0;
      cnt     <= 4'b0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            f3_q    <= funct3_i;
            if (WAIT_CYCLES == 0) begin
              state   <= S_RESP;
              ack_o   <= 1'b1;
              err_o   <= acc_err;
              rdata_o <= resp_data;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= S_RESP;
            ack_o   <= 1'b1;
            err_o   <= acc_err;
            rdata_o <= resp_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state   <= S_IDLE;
          ack_o   <= 1'b0;
          err_o   <= 1'b0;
          rdata_o <= 32'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with none, checked against hand-computed expected values.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [2:0]  f3    [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        busy  [2];
  logic        err   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_wait (
    .clk(clk), .reset(reset), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .funct3_i(f3[0]), .ack_o(ack[0]), .rdata_o(rdata[0]),
    .busy_o(busy[0]), .err_o(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut_fast (
    .clk(clk), .reset(reset), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .funct3_i(f3[1]), .ack_o(ack[1]), .rdata_o(rdata[1]),
    .busy_o(busy[1]), .err_o(err[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request from the current cycle and waits (bounded) for its ack.
  task automatic applyStimulus(input int sel, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [2:0] f,
                               output logic [31:0] rd, output logic e,
                               output int lat, output int busy_cnt);
    bit got = 0;
    req[sel] = 1'b1; we[sel] = w; addr[sel] = a; wdata[sel] = d; f3[sel] = f;
    lat = 0; busy_cnt = 0; rd = 32'hx; e = 1'bx;
    #1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy[sel]) busy_cnt++;
      @(posedge clk); #1;
      lat++;
      if (ack[sel]) begin
        got = 1;
        rd  = rdata[sel];
        e   = err[sel];
        checkOutput("busy_low_at_ack", 32'(busy[sel]), 32'd0);
      end
    end
    req[sel] = 1'b0;
    if (!got) checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  int          bc;
  int          ack_seen;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      req[s] = 0; we[s] = 0; addr[s] = 0; wdata[s] = 0; f3[s] = 0;
    end

    // Reset state and combinational busy while idle
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ack", 32'(ack[0]), 32'd0);
    checkOutput("reset_err", 32'(err[0]), 32'd0);
    checkOutput("reset_rdata", rdata[0], 32'd0);
    checkOutput("reset_busy_noreq", 32'(busy[0]), 32'd0);
    req[0] = 1'b1;
    #1;
    checkOutput("reset_busy_req", 32'(busy[0]), 32'd1);
    req[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset during WAIT abandons the store
    applyStimulus(0, 1'b1, 32'h20, 32'h0, 3'b010, rd, e, lat, bc);
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hDEADBEEF; f3[0] = 3'b010;
    @(posedge clk); #1;
    reset = 1'b1;
    req[0] = 1'b0;
    #1;
    checkOutput("rst_mid_ack", 32'(ack[0]), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack[0]) ack_seen++;
    end
    checkOutput("rst_no_ack", 32'(ack_seen), 32'd0);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 3'b010, rd, e, lat, bc);
    checkOutput("rst_lw_0x20", rd, 32'h0);

    // Latency and busy profile of SW with two wait states
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 32'h40, 32'hDEADBEEF, 3'b010, rd, e, lat, bc);
    checkOutput("sw_latency", 32'(lat), 32'd3);
    checkOutput("sw_busy_cycles", 32'(bc), 32'd3);
    checkOutput("sw_err", 32'(e), 32'd0);
    checkOutput("sw_rdata", rd, 32'd0);
    @(posedge clk); #1;
    checkOutput("sw_ack_one_cycle", 32'(ack[0]), 32'd0);

    // Load lanes with sign and zero extension
    applyStimulus(0, 1'b0, 32'h43, 32'h0, 3'b000, rd, e, lat, bc);
    checkOutput("lb_0x43", rd, 32'hFFFFFFDE);
    applyStimulus(0, 1'b0, 32'h43, 32'h0, 3'b100, rd, e, lat, bc);
    checkOutput("lbu_0x43", rd, 32'h000000DE);
    applyStimulus(0, 1'b0, 32'h42, 32'h0, 3'b001, rd, e, lat, bc);
    checkOutput("lh_0x42", rd, 32'hFFFFDEAD);
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 3'b101, rd, e, lat, bc);
    checkOutput("lhu_0x40", rd, 32'h0000BEEF);

    // Byte store keeps other lanes; load directly after is read-after-write
    applyStimulus(0, 1'b1, 32'h41, 32'hAABBCC11, 3'b000, rd, e, lat, bc);
    checkOutput("sb_err", 32'(e), 32'd0);
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 3'b010, rd, e, lat, bc);
    checkOutput("raw_lw_0x40", rd, 32'hDEAD11EF);

    // Error cases: flag set, data zero, word at 0x40 untouched
    applyStimulus(0, 1'b0, 32'h42, 32'h0, 3'b010, rd, e, lat, bc);
    checkOutput("lw_mis_err", 32'(e), 32'd1);
    checkOutput("lw_mis_rdata", rd, 32'd0);
    applyStimulus(0, 1'b1, 32'h41, 32'hFFFFFFFF, 3'b001, rd, e, lat, bc);
    checkOutput("sh_mis_err", 32'(e), 32'd1);
    checkOutput("sh_mis_rdata", rd, 32'd0);
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 3'b010, rd, e, lat, bc);
    checkOutput("sh_mis_word", rd, 32'hDEAD11EF);
    applyStimulus(0, 1'b1, 32'h40, 32'h0, 3'b011, rd, e, lat, bc);
    checkOutput("f3_011_err", 32'(e), 32'd1);
    checkOutput("f3_011_rdata", rd, 32'd0);
    applyStimulus(0, 1'b1, 32'h40, 32'h0, 3'b100, rd, e, lat, bc);
    checkOutput("sbu_illegal_err", 32'(e), 32'd1);
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 3'b010, rd, e, lat, bc);
    checkOutput("illegal_word", rd, 32'hDEAD11EF);
    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 3'b010, rd, e, lat, bc);
    checkOutput("range_err", 32'(e), 32'd1);
    checkOutput("range_rdata", rd, 32'd0);
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 3'b010, rd, e, lat, bc);
    checkOutput("range_word", rd, 32'hDEAD11EF);

    // Zero wait states: store, then back-to-back loads with req held
    applyStimulus(1, 1'b1, 32'h8, 32'h12345678, 3'b010, rd, e, lat, bc);
    checkOutput("fast_sw_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h8; wdata[1] = 32'h0; f3[1] = 3'b010;
    #1;
    checkOutput("b2b_busy_idle", 32'(busy[1]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("b2b_ack_%0d", i), 32'(ack[1]), 32'((i % 2) == 0));
      checkOutput($sformatf("b2b_busy_%0d", i), 32'(busy[1]), 32'((i % 2) != 0));
      if ((i % 2) == 0) checkOutput($sformatf("b2b_rdata_%0d", i), rdata[1], 32'h12345678);
    end
    req[1] = 1'b0;
    @(posedge clk); #1;

    // Depth boundary on the 16-word instance
    applyStimulus(1, 1'b0, 32'h3C, 32'h0, 3'b010, rd, e, lat, bc);
    checkOutput("last_word_err", 32'(e), 32'd0);
    applyStimulus(1, 1'b0, 32'h40, 32'h0, 3'b010, rd, e, lat, bc);
    checkOutput("past_end_err", 32'(e), 32'd1);
    checkOutput("past_end_rdata", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the skylark-v core: the memory-side end of the data access interface that the control path drives via `MemWriteW`. It accepts one load or store request at a time from the Writeback stage and performs byte, halfword or word accesses on an internal word-organised SRAM. It inserts a programmable number of wait states, holds `busy_o` so the hazard unit stalls the pipeline, and completes each access with a one-cycle `ack_o`. Load data is returned sign- or zero-extended.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the array; legal range is 1..65536.
- `WAIT_CYCLES`, default 2: wait states between acceptance and response; legal range is 0..15.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_i`  in  1  request valid; held high by the core until `ack_o`.
- `we_i`  in  1  1 = store, 0 = load; driven from `MemWriteW`.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data, right-aligned.
- `funct3_i`  in  3  access size and sign, RV32I encoding.
- `ack_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  32  load result; valid while `ack_o` is high.
- `busy_o`  out  1  stall request to the hazard control unit.
- `err_o`  out  1  error flag; pulses together with `ack_o`.

## Operation
- FSM has three states: IDLE, WAIT and RESP.
- IDLE with `req_i`=1: latch `we_i`, `addr_i`, `wdata_i` and `funct3_i`. Go to WAIT with counter = `WAIT_CYCLES`-1. If `WAIT_CYCLES`=0, go straight to RESP.
- WAIT: decrement the counter. When the counter reaches 0, go to RESP. Input changes during WAIT are ignored; only the latched request is used.
- RESP: `ack_o`=1 for exactly this one cycle, then go to IDLE. `req_i` is ignored in RESP. A new request is accepted no earlier than the following IDLE cycle.
- `busy_o` = (IDLE and `req_i`) or WAIT. It is 0 in RESP, so the core advances on the ack cycle.
- `funct3_i` decoding:
  - 000 = LB/SB
  - 001 = LH/SH
  - 010 = LW/SW
  - 100 = LBU
  - 101 = LHU
  - 011, 110 and 111 are illegal. Stores using 100 or 101 are also illegal.
- An error exists when any of the following holds:
  - `funct3` is illegal;
  - a halfword access has `addr[0]`=1;
  - a word access has `addr[1:0]`≠0;
  - `addr[31:2]` ≥ `DEPTH_WORDS`.
- On error: `err_o`=1 in the RESP cycle, `rdata_o`=0, and no array write occurs.
- Store:
  - Word index is `addr[31:2]`.
  - SB writes `wdata[7:0]` into byte lane `addr[1:0]`.
  - SH writes `wdata[15:0]` into halfword lane `addr[1]`.
  - SW writes the whole word.
  - Lanes not written are preserved.
  - The write commits at the edge that ends RESP.
  - Store acks drive `rdata_o`=0.
- Load:
  - Select the lane using the same rule as stores.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - The result is registered into `rdata_o` on the edge entering RESP.
- Array contents are not reset; the initial value is undefined.

## Timing
- Reset values: FSM=IDLE, `ack_o`=0, `err_o`=0, `rdata_o`=0. `busy_o` follows `req_i` combinationally.
- Latency: a request sampled in IDLE at edge N gives `ack_o` high in cycle N+1+`WAIT_CYCLES`.
  - With `WAIT_CYCLES`=0, ack comes one cycle after acceptance.
  - Maximum throughput is one access per `WAIT_CYCLES`+2 cycles.
- Outside ack cycles, `rdata_o` holds 0 and `err_o` is 0.
- Read-after-write: a load accepted in the IDLE cycle after a store's RESP sees the stored data.
- Reset asserted mid-access: return to IDLE immediately and abandon the pending store. The array is unchanged, and no ack is ever issued for that request.
- `req_i` falling before ack is a protocol violation. The latched access still completes.

## Test plan
- Reset mid-WAIT during SW 0xDEADBEEF to 0x20 (word previously 0x0) → `ack_o` never pulses; a subsequent LW 0x20 returns 0x00000000.
- `WAIT_CYCLES`=2: SW 0xDEADBEEF to 0x40 accepted at edge N → `busy_o` high in cycles N, N+1 and N+2; `ack_o` high only in cycle N+3; `err_o`=0.
- After that store, LB 0x43 → `rdata_o`=0xFFFFFFDE. LBU 0x43 → 0x000000DE. LH 0x42 → 0xFFFFDEAD. LHU 0x40 → 0x0000BEEF.
- SB 0x11 to 0x41 over 0xDEADBEEF, then LW 0x40 → 0xDEAD11EF.
- Errors, each checked for `err_o`=1, `rdata_o`=0 and the word at 0x40 unchanged:
  - LW at 0x42;
  - SH at 0x41;
  - funct3=011;
  - LW at `DEPTH_WORDS`*4.
- `WAIT_CYCLES`=0 with back-to-back loads and `req_i` held high → acks in alternate cycles; `busy_o` low in every ack cycle.
